dma_ch_reg_bank: RTL and testbench

Single-channel DMA configuration/status register bank that sits directly downstream of the APB4 slave front-end. It decodes the front-end's registered `cfg_*` access strobes into a fixed 0x00–0x90 register map. It drives configuration and start/stop command pulses to the channel transfer engine, and collects done/error events from it into sticky status bits and one level interrupt.

---
 rtl/dma_reg_pkg.sv | 48 ++++
 rtl/dma_ch_reg_bank.sv | 147 ++++++++++++++
 tb/tb_dma_ch_reg_bank.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_reg_pkg.sv
// Register map, bit positions and reset values shared by the DMA channel
// register bank and anything that needs to decode its map.
package dma_reg_pkg;

  localparam logic [31:0] CMD_ADDR     = 32'h0000_0000;
  localparam logic [31:0] STATUS_ADDR  = 32'h0000_0004;
  localparam logic [31:0] INTREN_ADDR  = 32'h0000_0008;
  localparam logic [31:0] CTRL_ADDR    = 32'h0000_000C;
  localparam logic [31:0] SRCADDR_ADDR = 32'h0000_0010;
  localparam logic [31:0] DESADDR_ADDR = 32'h0000_0018;
  localparam logic [31:0] XSIZE_ADDR   = 32'h0000_0020;
  localparam logic [31:0] ERRINFO_ADDR = 32'h0000_0080;
  localparam logic [31:0] IIDR_ADDR    = 32'h0000_008C;
  localparam logic [31:0] AIDR_ADDR    = 32'h0000_0090;

  localparam int CMD_ENABLE_BIT = 0;
  localparam int CMD_STOP_BIT   = 1;
  localparam int CMD_CLEAR_BIT  = 2;
  localparam int CMD_BUSY_BIT   = 0;
  localparam int ST_DONE_BIT    = 0;
  localparam int ST_ERR_BIT     = 1;
  localparam int ST_BUSY_BIT    = 16;
  localparam int IE_DONE_BIT    = 0;
  localparam int IE_ERR_BIT     = 1;

  typedef struct packed {
    logic err;
    logic done;
  } status_t;

  typedef struct packed {
    logic err_ie;
    logic done_ie;
  } intren_t;

  localparam logic [31:0] CTRL_RST    = 32'h0;
  localparam logic [31:0] SRCADDR_RST = 32'h0;
  localparam logic [31:0] DESADDR_RST = 32'h0;
  localparam logic [31:0] XSIZE_RST   = 32'h0;
  localparam logic [31:0] ERRINFO_RST = 32'h0;
  localparam status_t     STATUS_RST  = '0;
  localparam intren_t     INTREN_RST  = '0;

  function automatic logic irq_pending(input status_t s, input intren_t ie);
    return (s.done & ie.done_ie) | (s.err & ie.err_ie);
  endfunction

endpackage

// File: rtl/dma_ch_reg_bank.sv
// Single-channel DMA config/status register bank: decodes front-end cfg_*
// strobes, issues start/stop pulses and folds engine events into status/irq.
module dma_ch_reg_bank
  import dma_reg_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IIDR_VAL   = 32'h0350_043B,
  parameter logic [31:0] AIDR_VAL   = 32'h0000_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  input  logic                  cfg_wr_en,
  input  logic                  cfg_rd_en,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  input  logic                  ch_busy,
  input  logic                  ch_done,
  input  logic                  ch_err,
  input  logic [31:0]           ch_errinfo,
  output logic                  ch_start,
  output logic                  ch_stop,
  output logic [31:0]           ch_ctrl,
  output logic [31:0]           ch_srcaddr,
  output logic [31:0]           ch_desaddr,
  output logic [31:0]           ch_xsize,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] ctrl_q, src_q, des_q, xsize_q, errinfo_q;
  intren_t               intren_q;
  status_t               status_q;
  logic                  start_q, stop_q, irq_q;

  // Full-address decode: nothing outside the map aliases onto a register.
  logic wr_cmd, wr_status, wr_intren, wr_ctrl, wr_src, wr_des, wr_xsize;

  always_comb begin
    wr_cmd    = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(CMD_ADDR));
    wr_status = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(STATUS_ADDR));
    wr_intren = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(INTREN_ADDR));
    wr_ctrl   = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(CTRL_ADDR));
    wr_src    = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(SRCADDR_ADDR));
    wr_des    = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(DESADDR_ADDR));
    wr_xsize  = cfg_wr_en && (cfg_addr == ADDR_WIDTH'(XSIZE_ADDR));
  end

  logic cmd_start, cmd_stop, cmd_clear, cfg_lock;
  logic clr_done, clr_err;

  always_comb begin
    cfg_lock  = ch_busy;
    cmd_start = wr_cmd && cfg_wdata[CMD_ENABLE_BIT] && !ch_busy && !status_q.err;
    cmd_stop  = wr_cmd && cfg_wdata[CMD_STOP_BIT] && ch_busy;
    cmd_clear = wr_cmd && cfg_wdata[CMD_CLEAR_BIT] && !ch_busy;
    clr_done  = wr_status && cfg_wdata[ST_DONE_BIT];
    clr_err   = wr_status && cfg_wdata[ST_ERR_BIT];
  end

  // Configuration registers; CLEAR and config writes never coincide since
  // they target different addresses.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q   <= CTRL_RST;
      src_q    <= SRCADDR_RST;
      des_q    <= DESADDR_RST;
      xsize_q  <= XSIZE_RST;
      intren_q <= INTREN_RST;
    end else if (cmd_clear) begin
      ctrl_q   <= CTRL_RST;
      src_q    <= SRCADDR_RST;
      des_q    <= DESADDR_RST;
      xsize_q  <= XSIZE_RST;
      intren_q <= INTREN_RST;
    end else begin
      if (wr_ctrl  && !cfg_lock) ctrl_q  <= cfg_wdata;
      if (wr_src   && !cfg_lock) src_q   <= cfg_wdata;
      if (wr_des   && !cfg_lock) des_q   <= cfg_wdata;
      if (wr_xsize && !cfg_lock) xsize_q <= cfg_wdata;
      if (wr_intren) intren_q <= intren_t'(cfg_wdata[IE_ERR_BIT:IE_DONE_BIT]);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= cmd_start;
      stop_q  <= cmd_stop;
    end
  end

  // Sticky status: an engine event in the same cycle as its W1C wins.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      status_q  <= STATUS_RST;
      errinfo_q <= ERRINFO_RST;
      irq_q     <= 1'b0;
    end else begin
      status_q.done <= ch_done | (status_q.done & ~clr_done);
      status_q.err  <= ch_err  | (status_q.err  & ~clr_err);
      if (ch_err)
        errinfo_q <= ch_errinfo;
      else if (clr_err)
        errinfo_q <= ERRINFO_RST;
      irq_q <= irq_pending(status_q, intren_q);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_WIDTH'(CMD_ADDR):     cfg_rdata[CMD_BUSY_BIT] = ch_busy;
      ADDR_WIDTH'(STATUS_ADDR): begin
        cfg_rdata[ST_DONE_BIT] = status_q.done;
        cfg_rdata[ST_ERR_BIT]  = status_q.err;
        cfg_rdata[ST_BUSY_BIT] = ch_busy;
      end
      ADDR_WIDTH'(INTREN_ADDR):  cfg_rdata = DATA_WIDTH'(intren_q);
      ADDR_WIDTH'(CTRL_ADDR):    cfg_rdata = ctrl_q;
      ADDR_WIDTH'(SRCADDR_ADDR): cfg_rdata = src_q;
      ADDR_WIDTH'(DESADDR_ADDR): cfg_rdata = des_q;
      ADDR_WIDTH'(XSIZE_ADDR):   cfg_rdata = xsize_q;
      ADDR_WIDTH'(ERRINFO_ADDR): cfg_rdata = errinfo_q;
      ADDR_WIDTH'(IIDR_ADDR):    cfg_rdata = DATA_WIDTH'(IIDR_VAL);
      ADDR_WIDTH'(AIDR_ADDR):    cfg_rdata = DATA_WIDTH'(AIDR_VAL);
      default:                   cfg_rdata = '0;
    endcase
  end

  assign ch_start   = start_q;
  assign ch_stop    = stop_q;
  assign ch_ctrl    = ctrl_q;
  assign ch_srcaddr = src_q;
  assign ch_desaddr = des_q;
  assign ch_xsize   = xsize_q;
  assign irq        = irq_q;

  // Front-end never issues a read and a write strobe together.
  a_rd_wr_excl: assert property (@(posedge PCLK) disable iff (PRESET)
    !(cfg_rd_en && cfg_wr_en));
  a_start_stop_excl: assert property (@(posedge PCLK) disable iff (PRESET)
    !(start_q && stop_q));

endmodule

// File: tb/tb_dma_ch_reg_bank.sv
// Bench for dma_ch_reg_bank: directed scenarios plus a randomized run
// checked against a register-level model of the channel.
module tb_dma_ch_reg_bank;

  localparam logic [31:0] IIDR = 32'h0350_043B;
  localparam logic [31:0] AIDR = 32'h0000_0001;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata, ch_errinfo;
  logic        cfg_wr_en, cfg_rd_en, ch_busy, ch_done, ch_err;
  logic        ch_start, ch_stop, irq;
  logic [31:0] ch_ctrl, ch_srcaddr, ch_desaddr, ch_xsize;

  int n_cmp = 0;
  int n_bad = 0;

  dma_ch_reg_bank dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_rdata(cfg_rdata),
    .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .ch_errinfo(ch_errinfo),
    .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_ctrl(ch_ctrl), .ch_srcaddr(ch_srcaddr), .ch_desaddr(ch_desaddr),
    .ch_xsize(ch_xsize), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: the register file as the programmer sees it.
  logic [31:0] m_reg [string];
  logic        m_done, m_err, m_start, m_stop, m_irq;

  task automatic model_reset();
    m_reg["ctrl"] = 0; m_reg["src"] = 0; m_reg["des"] = 0; m_reg["xsize"] = 0;
    m_reg["ie"] = 0; m_reg["errinfo"] = 0;
    m_done = 0; m_err = 0; m_start = 0; m_stop = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    case (a)
      32'h00: return {31'b0, ch_busy};
      32'h04: return {15'b0, ch_busy, 14'b0, m_err, m_done};
      32'h08: return m_reg["ie"];
      32'h0C: return m_reg["ctrl"];
      32'h10: return m_reg["src"];
      32'h18: return m_reg["des"];
      32'h20: return m_reg["xsize"];
      32'h80: return m_reg["errinfo"];
      32'h8C: return IIDR;
      32'h90: return AIDR;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic        wr;
    logic [31:0] d;
    logic        ie_done, ie_err, nd, ne;
    if (PRESET) begin
      model_reset();
      return;
    end
    wr = cfg_wr_en; d = cfg_wdata;
    ie_done = m_reg["ie"][0]; ie_err = m_reg["ie"][1];
    m_irq   = (m_done && ie_done) || (m_err && ie_err);
    m_start = wr && cfg_addr == 32'h00 && d[0] && !ch_busy && !m_err;
    m_stop  = wr && cfg_addr == 32'h00 && d[1] && ch_busy;
    if (wr && cfg_addr == 32'h00 && d[2] && !ch_busy) begin
      m_reg["ctrl"] = 0; m_reg["src"] = 0; m_reg["des"] = 0;
      m_reg["xsize"] = 0; m_reg["ie"] = 0;
    end
    if (wr && !ch_busy) begin
      if (cfg_addr == 32'h0C) m_reg["ctrl"]  = d;
      if (cfg_addr == 32'h10) m_reg["src"]   = d;
      if (cfg_addr == 32'h18) m_reg["des"]   = d;
      if (cfg_addr == 32'h20) m_reg["xsize"] = d;
    end
    if (wr && cfg_addr == 32'h08) m_reg["ie"] = {30'b0, d[1:0]};
    nd = ch_done || (m_done && !(wr && cfg_addr == 32'h04 && d[0]));
    ne = ch_err  || (m_err  && !(wr && cfg_addr == 32'h04 && d[1]));
    if (ch_err) m_reg["errinfo"] = ch_errinfo;
    else if (wr && cfg_addr == 32'h04 && d[1]) m_reg["errinfo"] = 0;
    m_done = nd; m_err = ne;
  endtask

  task automatic tick();
    model_step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    cfg_addr = a; cfg_rd_en = 1'b1;
    #1 v = cfg_rdata;
    tick();
    cfg_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18,
                                32'h20, 32'h80, 32'h8C, 32'h90, 32'h44};
    logic [31:0] v, e;
    PRESET = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({ch_start, ch_stop, irq} !== 3'b0 || ch_ctrl !== 0 || ch_srcaddr !== 0 ||
        ch_desaddr !== 0 || ch_xsize !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got start=%b stop=%b irq=%b ctrl=%h src=%h, expected all 0",
               ch_start, ch_stop, irq, ch_ctrl, ch_srcaddr);
    end
    PRESET = 1'b0;
    tick();
    foreach (addrs[i]) begin
      e = (addrs[i] == 32'h8C) ? IIDR : (addrs[i] == 32'h90) ? AIDR : 32'h0;
      do_read(addrs[i], v);
      n_cmp++;
      if (v !== e) begin
        n_bad++;
        $display("FAIL reset_read_%h: got %h expected %h", addrs[i], v, e);
      end
    end
  endtask

  task automatic test_config_lock();
    logic [31:0] v;
    do_write(32'h10, 32'hDEAD_BEEF);
    do_read(32'h10, v);
    n_cmp++;
    if (v !== 32'hDEAD_BEEF || ch_srcaddr !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL src_write: got rd=%h out=%h expected deadbeef", v, ch_srcaddr);
    end
    ch_busy = 1'b1;
    do_write(32'h10, 32'h0000_1234);
    do_read(32'h10, v);
    n_cmp++;
    if (v !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL src_locked: got %h expected deadbeef", v);
    end
    ch_busy = 1'b0;
  endtask

  task automatic test_start_stop();
    ch_busy = 1'b0;
    do_write(32'h00, 32'h1);
    n_cmp++;
    if (ch_start !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %b expected 1", ch_start); end
    tick();
    n_cmp++;
    if (ch_start !== 1'b0) begin n_bad++; $display("FAIL start_width: got %b expected 0", ch_start); end
    ch_busy = 1'b1;
    do_write(32'h00, 32'h1);
    n_cmp++;
    if (ch_start !== 1'b0) begin n_bad++; $display("FAIL start_busy: got %b expected 0", ch_start); end
    do_write(32'h00, 32'h2);
    n_cmp++;
    if (ch_stop !== 1'b1) begin n_bad++; $display("FAIL stop_pulse: got %b expected 1", ch_stop); end
    tick();
    n_cmp++;
    if (ch_stop !== 1'b0) begin n_bad++; $display("FAIL stop_width: got %b expected 0", ch_stop); end
    ch_busy = 1'b0;
    do_write(32'h00, 32'h3);
    n_cmp++;
    if ({ch_start, ch_stop} !== 2'b10) begin
      n_bad++; $display("FAIL enable_and_stop_idle: got %b expected 10", {ch_start, ch_stop});
    end
    tick();
  endtask

  task automatic test_done_irq();
    do_write(32'h08, 32'h1);
    ch_done = 1'b1;
    tick();
    ch_done = 1'b0;
    cfg_addr = 32'h04;
    #1;
    n_cmp++;
    if (cfg_rdata !== 32'h1 || irq !== 1'b0) begin
      n_bad++; $display("FAIL done_status: got st=%h irq=%b expected 1/0", cfg_rdata, irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL done_irq_rise: got %b expected 1", irq); end
    do_write(32'h04, 32'h1);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b expected 1", irq); end
    tick();
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    ch_err = 1'b1; ch_errinfo = 32'h55;
    do_write(32'h04, 32'h2);
    ch_err = 1'b0;
    do_read(32'h04, v);
    n_cmp++;
    if (v[1] !== 1'b1) begin n_bad++; $display("FAIL collision_err: got %h expected bit1 set", v); end
    do_read(32'h80, v);
    n_cmp++;
    if (v !== 32'h55) begin n_bad++; $display("FAIL collision_info: got %h expected 55", v); end
    do_write(32'h04, 32'h2);
    do_read(32'h04, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL err_clear: got %h expected 0", v); end
    do_read(32'h80, v);
    n_cmp++;
    if (v !== 32'h0) begin n_bad++; $display("FAIL errinfo_clear: got %h expected 0", v); end
  endtask

  task automatic test_clear();
    logic [31:0] a5 [5] = '{32'h0C, 32'h10, 32'h18, 32'h20, 32'h08};
    logic [31:0] d5 [5] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h3};
    logic [31:0] v;
    for (int pass = 0; pass < 2; pass++) begin
      ch_busy = 1'b0;
      foreach (a5[i]) do_write(a5[i], d5[i]);
      ch_busy = (pass == 1);
      do_write(32'h00, 32'h4);
      foreach (a5[i]) begin
        do_read(a5[i], v);
        n_cmp++;
        if (v !== ((pass == 1) ? d5[i] : 32'h0)) begin
          n_bad++;
          $display("FAIL clear_busy%0d_%h: got %h expected %h", pass, a5[i], v,
                   (pass == 1) ? d5[i] : 32'h0);
        end
      end
    end
    ch_busy = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_write(32'h04, 32'h3);
    do_write(32'h10, 32'hCAFE_0000);
    do_write(32'h00, 32'h1);
    PRESET = 1'b1;
    #1;
    n_cmp++;
    if (ch_start !== 1'b0 || ch_srcaddr !== 32'h0) begin
      n_bad++; $display("FAIL reset_mid: got start=%b src=%h expected 0/0", ch_start, ch_srcaddr);
    end
    tick();
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18,
                               32'h20, 32'h80, 32'h8C, 32'h90, 32'h44, 32'h14};
    logic [31:0] a, e;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) ch_busy = ~ch_busy;
      ch_done = ($urandom_range(0, 9) == 0);
      ch_err  = ($urandom_range(0, 11) == 0);
      ch_errinfo = $urandom;
      a = pool[$urandom_range(0, 11)];
      cfg_addr = a;
      if (c % 2 == 0 && $urandom_range(0, 1) == 1) begin
        cfg_wr_en = 1'b1;
        cfg_wdata = (a == 32'h00) ? 32'($urandom_range(0, 7)) :
                    (a == 32'h04) ? 32'($urandom_range(0, 3)) : $urandom;
      end else begin
        cfg_wr_en = 1'b0;
        #1;
        e = exp_read(a);
        n_cmp++;
        if (cfg_rdata !== e) begin
          n_bad++; $display("FAIL rnd_read_%h cyc %0d: got %h expected %h", a, c, cfg_rdata, e);
        end
      end
      tick();
      n_cmp++;
      if (ch_start !== m_start || ch_stop !== m_stop || irq !== m_irq ||
          ch_ctrl !== m_reg["ctrl"] || ch_srcaddr !== m_reg["src"] ||
          ch_desaddr !== m_reg["des"] || ch_xsize !== m_reg["xsize"]) begin
        n_bad++;
        $display("FAIL rnd_outputs cyc %0d: got st=%b sp=%b irq=%b ctrl=%h src=%h des=%h xs=%h expected %b %b %b %h %h %h %h",
                 c, ch_start, ch_stop, irq, ch_ctrl, ch_srcaddr, ch_desaddr, ch_xsize,
                 m_start, m_stop, m_irq, m_reg["ctrl"], m_reg["src"], m_reg["des"], m_reg["xsize"]);
      end
    end
    cfg_wr_en = 1'b0; ch_done = 1'b0; ch_err = 1'b0; ch_busy = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    cfg_addr = 0; cfg_wdata = 0; cfg_wr_en = 0; cfg_rd_en = 0;
    ch_busy = 0; ch_done = 0; ch_err = 0; ch_errinfo = 0;
    model_reset();
    test_reset();
    test_config_lock();
    test_start_stop();
    test_done_irq();
    test_collision();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
